// File: rtl/mux_n1_pipe.sv
// ---------------------------------------------------------------------------
// mux_n1_pipe
//
// N-to-1 registered channel multiplexer with a valid/ready handshake on
// every input channel and on the output. A channel pointer selects which
// input may be accepted. The pointer is either held (static mode) or
// advanced after each accept (round-robin mode). It can be reloaded at any
// time through sel/sel_load.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in         N packed signed samples, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (only the pointed-at channel can be high)
//   sel        channel number to load into the pointer
//   sel_load   load strobe for sel
//   mode       0 = static select, 1 = round-robin auto-advance
//   out        registered selected sample
//   out_valid  out holds an unconsumed sample
//   out_ready  downstream accepts out this cycle
//   out_ch     channel that produced the current out
//   ptr        current channel pointer
//   sel_err    one-cycle pulse after a load with sel >= N
// ---------------------------------------------------------------------------
module mux_n1_pipe #(
  parameter int WIDTH = 165,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_load,
  input  logic               mode,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch,
  output logic [SEL_W-1:0]   ptr,
  output logic               sel_err
);

  // The pointer can address 2^SEL_W slots. Slots at or above N are padded
  // with zero data and never-valid, so a pointer index is always in range.
  localparam int               SLOTS  = 1 << SEL_W;
  localparam logic [SEL_W:0]   N_EXT  = N[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N - 1);

  logic [WIDTH-1:0] chan [SLOTS];
  logic [SLOTS-1:0] valid_pad;

  logic [WIDTH-1:0] out_reg,       out_next;
  logic             out_valid_reg, out_valid_next;
  logic [SEL_W-1:0] out_ch_reg,    out_ch_next;
  logic [SEL_W-1:0] ptr_reg,       ptr_next;
  logic             sel_err_reg,   sel_err_next;

  logic             stage_free;
  logic             accept;
  logic             sel_ok;

  // Unpack the flat input bus into per-slot views.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < N) begin : g_real
        assign chan[gi]      = in[gi*WIDTH +: WIDTH];
        assign valid_pad[gi] = in_valid[gi];
      end else begin : g_pad
        assign chan[gi]      = '0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // The output register can take a new sample when it is empty or is being
  // drained in this same cycle.
  assign stage_free = !out_valid_reg || out_ready;

  // Ready is one-hot on the pointed-at channel and gated by stage_free.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = stage_free && (ptr_reg == SEL_W'(gi));
    end
  endgenerate

  assign accept = valid_pad[ptr_reg] && stage_free;

  // Widen by one bit so the comparison also works when 2^SEL_W == N.
  assign sel_ok = ({1'b0, sel} < N_EXT);

  always_comb begin
    out_next       = out_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    sel_err_next   = sel_load && !sel_ok;

    // Data path: an accept loads a new sample. A free stage with no accept
    // empties, and a stalled stage holds. out/out_ch keep their last value
    // when the stage empties.
    if (accept) begin
      out_next       = chan[ptr_reg];
      out_ch_next    = ptr_reg;
      out_valid_next = 1'b1;
    end else if (stage_free) begin
      out_valid_next = 1'b0;
    end

    // A valid load overrides any round-robin advance. The accept above has
    // already used the old pointer. An out-of-range load is ignored, so the
    // advance still happens.
    if (sel_load && sel_ok) begin
      ptr_next = sel;
    end else if (mode && accept) begin
      ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
      sel_err_reg   <= 1'b0;
    end else begin
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      out_ch_reg    <= out_ch_next;
      ptr_reg       <= ptr_next;
      sel_err_reg   <= sel_err_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign ptr       = ptr_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_mux_n1_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_n1_pipe
//
// Directed bench for mux_n1_pipe with N=4, SEL_W=3 (so sel=5 is an
// out-of-range select), WIDTH=165. A reference model tracks the pointer,
// out_valid, out_ch and sel_err. Accepted samples are queued in a
// scoreboard and compared when the output handshake completes.
// ---------------------------------------------------------------------------
module tb_mux_n1_pipe;
  localparam int WIDTH = 165;
  localparam int N     = 4;
  localparam int SEL_W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_bus;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               sel_load;
  logic               mode;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;
  logic [SEL_W-1:0]   ptr;
  logic               sel_err;

  logic signed [WIDTH-1:0] chan_val [N];

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] ch;
  } exp_t;
  exp_t sb[$];

  logic             m_valid;
  logic [SEL_W-1:0] m_ptr;
  logic [SEL_W-1:0] m_ch;
  logic             m_err;
  bit               model_ok = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] neg5;

  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < N; k++) in_bus[k*WIDTH +: WIDTH] = chan_val[k];
  end

  mux_n1_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_bus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .sel_load  (sel_load),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .ptr       (ptr),
    .sel_err   (sel_err)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs and the scoreboard before the
  // edge, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    logic             free;
    logic             acc;
    logic [N-1:0]     exp_rdy;
    exp_t             e;
    #1;
    if (rst_n && model_ok) begin
      free    = !m_valid || out_ready;
      exp_rdy = '0;
      if (free) exp_rdy[m_ptr] = 1'b1;
      chk("in_ready", in_ready, exp_rdy);
      if (m_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", out, e.data);
          chk("out_ch", out_ch, e.ch);
        end
      end
      acc = in_valid[m_ptr] && free;
      if (acc) sb.push_back({chan_val[m_ptr], m_ptr});
      if (acc) begin
        m_valid = 1'b1;
        m_ch    = m_ptr;
      end else if (free) begin
        m_valid = 1'b0;
      end
      m_err = sel_load && (int'(sel) >= N);
      if (sel_load && int'(sel) < N) m_ptr = sel;
      else if (mode && acc) m_ptr = (int'(m_ptr) == N - 1) ? '0 : m_ptr + 1'b1;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_ptr    = '0;
      m_ch     = '0;
      m_err    = 1'b0;
      model_ok = 1'b1;
      sb.delete();
      chk("rst_out", out, '0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_ptr", ptr, 0);
      chk("rst_sel_err", sel_err, 0);
    end else if (model_ok) begin
      chk("out_valid", out_valid, m_valid);
      chk("ptr", ptr, m_ptr);
      chk("sel_err", sel_err, m_err);
      if (m_valid) chk("out_ch_held", out_ch, m_ch);
    end
    @(negedge clk);
  endtask

  initial begin
    neg5      = '1;
    neg5[2:0] = 3'b011;
    rst_n     = 1'b0;
    sel       = '0;
    sel_load  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = '0;
    for (int k = 0; k < N; k++) chan_val[k] = '0;

    // Reset, then only channel 0 ready.
    cycle();
    cycle();
    chk("post_rst_in_ready", in_ready, 4'b0001);

    // Static select of channel 2 carrying -5.
    rst_n     = 1'b1;
    sel       = 3'd2;
    sel_load  = 1'b1;
    out_ready = 1'b1;
    cycle();
    sel_load    = 1'b0;
    chan_val[2] = -5;
    in_valid    = 4'b0100;
    cycle();
    chk("neg5_out", out, neg5);
    chk("neg5_ch", out_ch, 2);
    chk("neg5_valid", out_valid, 1);
    chk("neg5_in_ready", in_ready, 4'b0100);
    in_valid = '0;
    cycle();

    // Round-robin streaming across all four channels, no bubbles.
    mode     = 1'b1;
    sel      = 3'd0;
    sel_load = 1'b1;
    cycle();
    sel_load = 1'b0;
    for (int k = 0; k < N; k++) chan_val[k] = 10 + k;
    in_valid = 4'b1111;
    repeat (6) cycle();
    in_valid = '0;
    cycle();

    // Back-pressure: out=7 holds for three stalled cycles.
    mode     = 1'b0;
    sel      = 3'd0;
    sel_load = 1'b1;
    cycle();
    sel_load    = 1'b0;
    chan_val[0] = 7;
    in_valid    = 4'b0001;
    cycle();
    out_ready   = 1'b0;
    chan_val[0] = 8;
    repeat (3) begin
      cycle();
      chk("stall_out", out, 7);
      chk("stall_in_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    cycle();
    chk("after_stall_out", out, 8);
    in_valid = '0;
    cycle();

    // Load during accept uses the old pointer; out-of-range load errors.
    mode     = 1'b1;
    sel      = 3'd3;
    sel_load = 1'b1;
    cycle();
    chan_val[3] = 33;
    in_valid    = 4'b1000;
    sel         = 3'd1;
    cycle();
    chk("load_acc_ch", out_ch, 3);
    chk("load_acc_ptr", ptr, 1);
    in_valid = '0;
    sel      = 3'd5;
    cycle();
    chk("sel_err_pulse", sel_err, 1);
    chk("sel_err_ptr", ptr, 1);
    sel_load = 1'b0;
    cycle();
    chk("sel_err_clear", sel_err, 0);

    // Round-robin waits on an idle channel.
    sel      = 3'd0;
    sel_load = 1'b1;
    cycle();
    sel_load    = 1'b0;
    chan_val[1] = 21;
    in_valid    = 4'b0010;
    repeat (3) cycle();
    chk("wait_ptr", ptr, 0);
    chk("wait_valid", out_valid, 0);

    // Mid-stream reset discards the held sample.
    mode     = 1'b0;
    sel      = 3'd2;
    sel_load = 1'b1;
    in_valid = '0;
    cycle();
    sel_load    = 1'b0;
    chan_val[2] = 99;
    in_valid    = 4'b0100;
    out_ready   = 1'b0;
    cycle();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ptr", ptr, 2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 4'b0001);
    out_ready = 1'b1;
    in_valid  = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
